priority_scan_encoder: RTL and testbench

//  Parametrised, sequential successor to the 16-bit combinational priority encoder.

---
 rtl/priority_scan_encoder.sv | 119 +++++++++++
 tb/tb_priority_scan_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/priority_scan_encoder.sv
// Registers a request vector and emits the index of each set bit as one beat, in priority order.
// Latency 1 cycle to first beat; out_ready=0 freezes all state; in_ready is high only in IDLE.
module priority_scan_encoder #(
    parameter int             WIDTH     = 16,
    parameter int             OUT_W     = 8,
    parameter logic [OUT_W-1:0] NONE_CODE = 8'hF0,
    parameter bit             MSB_FIRST = 1'b1,
    localparam int            IDX_W     = $clog2(WIDTH),
    localparam int            CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_code,
    output logic             out_none,
    output logic             out_last,
    output logic [CNT_W-1:0] out_seq
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pending;
    logic [CNT_W-1:0]   r_seq;
    logic               r_empty;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_pending_nxt;
    logic [CNT_W-1:0]   w_seq_nxt;
    logic               w_empty_nxt;

    logic [IDX_W-1:0]   w_idx;
    logic               w_single;
    logic               w_last;
    logic               w_emit;
    logic [WIDTH-1:0]   w_served_mask;

    // Later loop iterations win, so scan direction picks the priority end.
    always_comb begin
        w_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_pending[i]) w_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (r_pending[i]) w_idx = IDX_W'(i);
            end
        end
    end

    assign w_single      = (r_pending != '0) && ((r_pending & (r_pending - WIDTH'(1))) == '0);
    assign w_last        = r_empty || w_single;
    assign w_emit        = (r_state == S_EMIT);
    assign w_served_mask = WIDTH'(1) << w_idx;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = w_emit;
    assign out_code  = !w_emit ? '0 : (r_empty ? NONE_CODE : OUT_W'(w_idx));
    assign out_none  = w_emit && r_empty;
    assign out_last  = w_emit && w_last;
    assign out_seq   = w_emit ? r_seq : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_seq_nxt     = r_seq;
        w_empty_nxt   = r_empty;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_pending_nxt = in_vec;
                    w_empty_nxt   = (in_vec == '0);
                    w_seq_nxt     = '0;
                    w_state_nxt   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt   = S_IDLE;
                        w_pending_nxt = '0;
                        w_seq_nxt     = '0;
                    end else begin
                        w_pending_nxt = r_pending & ~w_served_mask;
                        w_seq_nxt     = r_seq + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = '0;
            w_seq_nxt     = '0;
            w_empty_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_seq     <= '0;
            r_empty   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_seq     <= w_seq_nxt;
            r_empty   <= w_empty_nxt;
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Drives an MSB-first and an LSB-first instance with identical stimulus and
// compares every beat against a bit-list model of the expected emission order.
module tb_priority_scan_encoder;

    localparam int WIDTH = 16;
    localparam int OUT_W = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [OUT_W-1:0] NONE = 8'hF0;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_vec;

    logic             m_in_ready, m_out_valid, m_out_none, m_out_last;
    logic [OUT_W-1:0] m_out_code;
    logic [CNT_W-1:0] m_out_seq;
    logic             l_in_ready, l_out_valid, l_out_none, l_out_last;
    logic [OUT_W-1:0] l_out_code;
    logic [CNT_W-1:0] l_out_seq;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_m[$];
    int exp_l[$];

    always #5 clk = ~clk;

    priority_scan_encoder dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_code(m_out_code),
        .out_none(m_out_none), .out_last(m_out_last), .out_seq(m_out_seq)
    );

    priority_scan_encoder #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_code(l_out_code),
        .out_none(l_out_none), .out_last(l_out_last), .out_seq(l_out_seq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected emission order: list of set-bit positions in priority order.
    task automatic build_model(input logic [WIDTH-1:0] v);
        exp_m.delete();
        exp_l.delete();
        if (v == '0) begin
            exp_m.push_back(int'(NONE));
            exp_l.push_back(int'(NONE));
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) exp_m.push_back(i);
            for (int i = 0; i < WIDTH; i++)      if (v[i]) exp_l.push_back(i);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_valid"}, 32'(m_out_valid), 32'd0);
        chk({tag, "_m_ready"}, 32'(m_in_ready), 32'd1);
        chk({tag, "_m_code"},  32'(m_out_code), 32'd0);
        chk({tag, "_m_last"},  32'(m_out_last), 32'd0);
        chk({tag, "_l_valid"}, 32'(l_out_valid), 32'd0);
        chk({tag, "_l_ready"}, 32'(l_in_ready), 32'd1);
    endtask

    task automatic check_beat(input string tag, input int k, input bit is_empty);
        int n;
        n = exp_m.size();
        chk({tag, "_m_valid"}, 32'(m_out_valid), 32'd1);
        chk({tag, "_m_ready"}, 32'(m_in_ready), 32'd0);
        chk({tag, "_m_code"},  32'(m_out_code), 32'(exp_m[k]));
        chk({tag, "_m_none"},  32'(m_out_none), 32'(is_empty));
        chk({tag, "_m_last"},  32'(m_out_last), 32'(k == n - 1));
        chk({tag, "_m_seq"},   32'(m_out_seq), 32'(k));
        chk({tag, "_l_valid"}, 32'(l_out_valid), 32'd1);
        chk({tag, "_l_code"},  32'(l_out_code), 32'(exp_l[k]));
        chk({tag, "_l_none"},  32'(l_out_none), 32'(is_empty));
        chk({tag, "_l_last"},  32'(l_out_last), 32'(k == n - 1));
        chk({tag, "_l_seq"},   32'(l_out_seq), 32'(k));
    endtask

    // fixed_stall >= 0 gives that many out_ready-low cycles before each beat,
    // otherwise a random 0..max_stall; toggle scrambles in_valid/in_vec during EMIT.
    task automatic send_vec(input string tag, input logic [WIDTH-1:0] v,
                            input int fixed_stall, input int max_stall, input bit toggle);
        int stalls;
        chk({tag, "_accept_ready"}, 32'(m_in_ready), 32'd1);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        build_model(v);
        for (int k = 0; k < exp_m.size(); k++) begin
            stalls = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, max_stall));
            for (int s = 0; s < stalls; s++) begin
                out_ready = 1'b0;
                if (toggle) begin
                    in_valid = 1'($urandom);
                    in_vec   = WIDTH'($urandom);
                end
                check_beat({tag, "_stall"}, k, v == '0);
                step();
            end
            out_ready = 1'b1;
            if (toggle) begin
                in_valid = 1'($urandom);
                in_vec   = WIDTH'($urandom);
            end
            check_beat(tag, k, v == '0);
            step();
        end
        in_valid = 1'b0;
        check_idle({tag, "_after"});
    endtask

    task automatic abort_run(input string tag, input bit use_rst);
        in_valid  = 1'b1;
        in_vec    = 16'h2AF1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        build_model(16'h2AF1);
        check_beat({tag, "_b0"}, 0, 1'b0);
        step();
        check_beat({tag, "_b1"}, 1, 1'b0);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        check_idle({tag, "_abort"});
        send_vec({tag, "_next"}, 16'h0001, 0, 0, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_m_seq",  32'(m_out_seq), 32'd0);
        chk("reset_m_none", 32'(m_out_none), 32'd0);

        send_vec("t1", 16'h2AF1, 0, 0, 1'b0);
        send_vec("t2", 16'h0001, 0, 0, 1'b0);
        send_vec("t3", 16'h0000, 0, 0, 1'b0);
        send_vec("t4", 16'hC000, 3, 0, 1'b0);
        abort_run("t5_flush", 1'b0);
        abort_run("t5_rst", 1'b1);
        send_vec("t6", 16'h2AF1, -1, 2, 1'b1);
        send_vec("msb_edge", 16'h8000, 1, 0, 1'b1);
        send_vec("full", 16'hFFFF, 0, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0:       rv = '0;
                1:       rv = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
                default: rv = WIDTH'($urandom);
            endcase
            send_vec("rand", rv, -1, 2, 1'($urandom));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
